// File: rtl/fptd_iter_ctrl.sv
// Iteration sequencer for a turbo-decoder section: CLEAR -> RUN (2*iter_lim cycles) -> FLUSH (PIPE_LAT) -> DONE.
// Start to first RUN cycle is 2 cycles; done holds until done_ack, abort wins. Macro FPTD_EARLY_STOP_EN adds stop_req/early_stop.
module fptd_iter_ctrl #(
  parameter int ITW      = 6,
  parameter int PIPE_LAT = 2
) (
  input  logic           Clock,
  input  logic           nReset,
  input  logic           start,
  input  logic [ITW-1:0] iter_max,
  input  logic           abort,
  input  logic           done_ack,
  output logic           nClear,
  output logic           Enable,
  output logic           even_phase,
  output logic [ITW-1:0] iter_cnt,
  output logic           busy,
  output logic           out_valid,
  output logic           done
`ifdef FPTD_EARLY_STOP_EN
  ,
  input  logic           stop_req,
  output logic           early_stop
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] FLUSH_LAST  = 4'(PIPE_LAT - 1);
  // With a single flush cycle, out_valid must already be set on entry to FLUSH.
  localparam logic       OV_ON_ENTRY = (PIPE_LAT == 1);

  state_t         state_q;
  logic [ITW-1:0] iter_lim_q;
  logic [ITW-1:0] iter_cnt_q;
  logic [ITW-1:0] iter_cnt_d;
  logic [3:0]     flush_cnt_q;
  logic [3:0]     flush_cnt_d;
  logic           nclear_q;
  logic           enable_q;
  logic           even_q;
  logic           busy_q;
  logic           out_valid_q;
  logic           done_q;
  logic           last_iter;
  logic           stop_hit;

  // iter_cnt_q < iter_lim_q <= 2^ITW-1 inside RUN, so the increment never wraps.
  assign iter_cnt_d  = iter_cnt_q + ITW'(1);
  assign flush_cnt_d = flush_cnt_q + 4'd1;
  assign last_iter   = (iter_cnt_d == iter_lim_q) || (iter_cnt_d == {ITW{1'b1}});

`ifdef FPTD_EARLY_STOP_EN
  logic early_stop_q;
  assign stop_hit   = stop_req;
  assign early_stop = early_stop_q;
`else
  assign stop_hit   = 1'b0;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= ST_IDLE;
      iter_lim_q  <= '0;
      iter_cnt_q  <= '0;
      flush_cnt_q <= '0;
      nclear_q    <= 1'b1;
      enable_q    <= 1'b0;
      even_q      <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef FPTD_EARLY_STOP_EN
      early_stop_q <= 1'b0;
`endif
    end else if (abort && (state_q != ST_IDLE)) begin
      // Abort beats done_ack and the RUN->FLUSH hand-off; the frame leaves no trace.
      state_q     <= ST_IDLE;
      nclear_q    <= 1'b1;
      enable_q    <= 1'b0;
      even_q      <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_CLEAR;
            iter_lim_q <= (iter_max == '0) ? ITW'(1) : iter_max;
            iter_cnt_q <= '0;
            nclear_q   <= 1'b0;
            busy_q     <= 1'b1;
`ifdef FPTD_EARLY_STOP_EN
            early_stop_q <= 1'b0;
`endif
          end
        end
        ST_CLEAR: begin
          state_q  <= ST_RUN;
          nclear_q <= 1'b1;
          enable_q <= 1'b1;
          even_q   <= 1'b1;
        end
        ST_RUN: begin
          even_q <= ~even_q;
          if (!even_q) begin
            iter_cnt_q <= iter_cnt_d;
            if (last_iter || stop_hit) begin
              state_q     <= ST_FLUSH;
              enable_q    <= 1'b0;
              flush_cnt_q <= '0;
              out_valid_q <= OV_ON_ENTRY;
`ifdef FPTD_EARLY_STOP_EN
              if (stop_hit) early_stop_q <= 1'b1;
`endif
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            even_q      <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_d;
            out_valid_q <= (flush_cnt_d == FLUSH_LAST);
            even_q      <= ~even_q;
          end
        end
        ST_DONE: begin
          // A start arriving with done_ack is dropped: IDLE must be seen first.
          if (done_ack) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          nclear_q    <= 1'b1;
          enable_q    <= 1'b0;
          even_q      <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign nClear     = nclear_q;
  assign Enable     = enable_q;
  assign even_phase = even_q;
  assign iter_cnt   = iter_cnt_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fptd_iter_ctrl.sv
// Directed bench for fptd_iter_ctrl; per-frame expectations go through a scoreboard queue.
module tb_fptd_iter_ctrl;
  localparam int ITW      = 6;
  localparam int PIPE_LAT = 2;

  logic           Clock;
  logic           nReset;
  logic           start;
  logic [ITW-1:0] iter_max;
  logic           abort;
  logic           done_ack;
  logic           nClear;
  logic           Enable;
  logic           even_phase;
  logic [ITW-1:0] iter_cnt;
  logic           busy;
  logic           out_valid;
  logic           done;
`ifdef FPTD_EARLY_STOP_EN
  logic           stop_req;
  logic           early_stop;
`endif

  typedef struct {
    int cnt;
    int runs;
    int early;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   en_seen = 0;
  int   ov_seen = 0;
  logic ov_prev;

  fptd_iter_ctrl #(.ITW(ITW), .PIPE_LAT(PIPE_LAT)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .start      (start),
    .iter_max   (iter_max),
    .abort      (abort),
    .done_ack   (done_ack),
    .nClear     (nClear),
    .Enable     (Enable),
    .even_phase (even_phase),
    .iter_cnt   (iter_cnt),
    .busy       (busy),
    .out_valid  (out_valid),
    .done       (done)
`ifdef FPTD_EARLY_STOP_EN
    ,
    .stop_req   (stop_req),
    .early_stop (early_stop)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Per-frame activity counters, restarted whenever the DUT clears its section.
  always @(negedge Clock) begin
    if (nClear === 1'b0) begin
      en_seen <= 0;
      ov_seen <= 0;
    end else begin
      if (Enable === 1'b1)    en_seen <= en_seen + 1;
      if (out_valid === 1'b1) ov_seen <= ov_seen + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_nclear"}, nClear, 1);
    check({tag, "_enable"}, Enable, 0);
    check({tag, "_even"},   even_phase, 1);
    check({tag, "_cnt"},    iter_cnt, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_ov"},     out_valid, 0);
    check({tag, "_done"},   done, 0);
`ifdef FPTD_EARLY_STOP_EN
    check({tag, "_early"},  early_stop, 0);
`endif
  endtask

  // Drives a one-cycle start; when push is set the frame's expected outcome is queued.
  task automatic start_frame(input int im, input bit push, input int stop_at);
    iter_max = im[ITW-1:0];
    start    = 1'b1;
    if (push) begin
      exp_t e;
      int   lim;
      lim     = (im == 0) ? 1 : im;
      e.cnt   = (stop_at != 0 && stop_at < lim) ? stop_at : lim;
      e.runs  = 2 * e.cnt;
      e.early = (stop_at != 0) ? 1 : 0;
      sb_q.push_back(e);
    end
    tick();
    start = 1'b0;
    check("clear_lo", nClear, 0);
    check("clear_en", Enable, 0);
    check("clear_busy", busy, 1);
  endtask

  // Waits for done, checks the frame against the scoreboard, then acknowledges it.
  task automatic finish_frame(input int budget, input bit ack_with_start, output int waited);
    bit   seen;
    exp_t e;
    seen   = 1'b0;
    waited = 0;
    e.cnt  = 0;
    e.runs = 0;
    e.early = 0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      ov_prev = out_valid;
      tick();
      waited++;
    end
    check("done_seen", seen, 1);
    check("ov_before_done", ov_prev, 1);
    check("done_ov_lo", out_valid, 0);
    check("sb_pending", (sb_q.size() > 0) ? 1 : 0, 1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check("final_cnt", iter_cnt, e.cnt);
    check("run_cycles", en_seen, e.runs);
    check("ov_pulses", ov_seen, 1);
`ifdef FPTD_EARLY_STOP_EN
    check("early_flag", early_stop, e.early);
`endif
    tick();
    check("done_hold", done, 1);
    done_ack = 1'b1;
    start    = ack_with_start;
    tick();
    done_ack = 1'b0;
    start    = 1'b0;
    check("ack_busy", busy, 0);
    check("ack_done", done, 0);
    check("cnt_hold", iter_cnt, e.cnt);
    tick();
    check("idle_busy", busy, 0);
    check("idle_nclear", nClear, 1);
  endtask

  initial begin
    int w;
    int done_cnt;
    nReset   = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    done_ack = 1'b0;
    iter_max = '0;
    ov_prev  = 1'b0;
`ifdef FPTD_EARLY_STOP_EN
    stop_req = 1'b0;
`endif
    #12;
    check_rst("rst");
    @(negedge Clock);
    nReset = 1'b1;

    // Nominal frame, started on the very first edge after reset release.
    start_frame(4, 1'b1, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      check("run_en", Enable, 1);
      check("run_even", even_phase, (k % 2 == 0) ? 1 : 0);
      check("run_cnt", iter_cnt, k / 2);
      tick();
    end
    check("flush_en", Enable, 0);
    check("flush_even0", even_phase, 1);
    check("flush_ov0", out_valid, 0);
    check("flush_cnt", iter_cnt, 4);
    check("flush_nclear", nClear, 1);
    tick();
    check("flush_ov1", out_valid, 1);
    check("flush_even1", even_phase, 0);
    finish_frame(20, 1'b0, w);
    check("nom_done_lat", w, 1);

    // iter_max of zero behaves as one iteration.
    start_frame(0, 1'b1, 0);
    finish_frame(20, 1'b0, w);

    // Largest iteration count.
    start_frame(63, 1'b1, 0);
    finish_frame(300, 1'b0, w);

    // Abort on the third RUN cycle.
    start_frame(5, 1'b0, 0);
    tick();
    tick();
    tick();
    check("abort_pre_en", Enable, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_en", Enable, 0);
    check("abort_done", done, 0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_no_ov", ov_seen, 0);

    // Abort on the last RUN cycle beats the move to FLUSH.
    start_frame(1, 1'b0, 0);
    tick();
    tick();
    check("lastrun_even", even_phase, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("lastrun_abort_busy", busy, 0);
    for (int i = 0; i < 10; i++) tick();
    check("lastrun_no_ov", ov_seen, 0);
    check("lastrun_no_done", done, 0);

    // start while busy is ignored, and start with done_ack is not accepted.
    start_frame(3, 1'b1, 0);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_frame(40, 1'b1, w);

    // Asynchronous reset in the middle of RUN.
    start_frame(6, 1'b0, 0);
    tick();
    tick();
    tick();
    check("pre_rst_en", Enable, 1);
    #3;
    nReset = 1'b0;
    #1;
    check_rst("async_rst");
    tick();
    check_rst("held_rst");
    @(negedge Clock);
    nReset = 1'b1;
    start_frame(2, 1'b1, 0);
    finish_frame(30, 1'b0, w);

`ifdef FPTD_EARLY_STOP_EN
    // stop_req in an even_phase=1 cycle is ignored; in the 2nd even_phase=0 cycle it stops RUN.
    start_frame(8, 1'b1, 2);
    tick();
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    check("es_ignored_en", Enable, 1);
    tick();
    tick();
    check("es_even", even_phase, 0);
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    finish_frame(20, 1'b0, w);
    check("es_done_lat", w, PIPE_LAT);
    start_frame(1, 1'b1, 0);
    check("es_clr", early_stop, 0);
    finish_frame(20, 1'b0, w);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
